// File: rtl/briskv_pkg.sv
// Shared UART types and constants for the briskv SoC peripherals.
package briskv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high during the last clock of every bit period.
module uart_baud_gen
  import briskv_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clear realigns the period to the accept edge of a new frame
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte over valid/ready and serialises it LSB first.
module uart_tx
  import briskv_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       TXD
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx_q;
  logic           txd_q;
  logic           tick;
  logic           accept;

  assign accept = valid && (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  // TXD is registered alongside the state so the line changes on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            state_q   <= START;
            shift_q   <= data;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign TXD   = txd_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter driving the SoC `TXD` pin, which the top level currently ties low. The core hands it one byte at a time over a valid/ready handshake. The block emits an 8N1 frame: start bit, 8 data bits LSB first, one stop bit, no parity. It runs on the undivided board clock, not the slow LED clock, and sits directly downstream of the core's output register as the consumer of its byte stream.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit (12 MHz / 115200). Legal range ≥ 2.
- `clk` input 1: board clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data` input 8: byte to send; sampled only on the accept edge.
- `valid` input 1: `data` is offered.
- `ready` output 1: block can accept a byte (state IDLE).
- `busy` output 1: frame in progress; equals `!ready`.
- `TXD` output 1: serial line, idle high; registered output.

## Operation
- Reset values: `TXD`=1, `ready`=1, `busy`=0, state IDLE, counters 0, shift register 0.
- States and transitions:
  - IDLE → START when `valid && ready` at an edge. This is the accept edge. `data` is latched into the shift register.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits × `CLKS_PER_BIT` cycles.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- `TXD` per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0; the register shifts right once per bit period.
  - STOP: 1.
- Baud counter:
  - Counts 0 to `CLKS_PER_BIT`-1; width `$clog2(CLKS_PER_BIT)`.
  - Wraps to 0 at each bit boundary.
  - Cleared on the accept edge.
- Bit index: 3 bits, 0 to 7. Leaves DATA when index 7 completes its period; no wrap beyond 7.
- `valid` while `ready`=0 is ignored, not queued. No error is flagged.
- Changing `data` after the accept edge has no effect on the frame in flight.
- `reset` asserted mid-frame:
  - Takes effect asynchronously: `TXD`=1 and `ready`=1 without waiting for an edge.
  - The partial frame is abandoned.
  - The first accept after release starts a full new frame.
- `valid` held high continuously: a new frame is accepted on every IDLE cycle.

## Timing
- The accept edge is E0.
- `TXD` falls at E0, registered in the same edge as the state change.
- Bit k (start=0, data 1..8, stop=9) occupies cycles E0+k·N to E0+(k+1)·N-1, where N=`CLKS_PER_BIT`.
- State returns to IDLE at edge E0+10N, where `ready` rises.
- Earliest next accept is edge E0+10N+1. Back-to-back frame period is 10N+1 cycles, with exactly one idle-high cycle between the stop bit and the next start bit.
- `ready`/`busy` are derived combinationally from the state register. There is no combinational path from `valid` or `data` to any output.

## Structure
- Shared package `briskv_pkg` holds:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - constants `UART_DATA_BITS`=8 and `UART_FRAME_BITS`=10;
  - default `UART_CLKS_PER_BIT`=104.
- Sub-module `uart_baud_gen`:
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `tick`, high in the last cycle of each bit period.
  - Reused by the future receiver.
- `uart_tx` holds the FSM, the shift register and the bit index.

## Test plan
All scenarios use N=4 unless stated.
- Reset: assert `reset` mid-simulation without a clock edge → `TXD`=1, `ready`=1, `busy`=0 immediately. They hold until the first accept after release.
- Single byte 0xA5 → `TXD` per 4-cycle slot reads 0,1,0,1,0,0,1,0,1,1. `ready`=0 for exactly 40 cycles starting E0.
- Back-to-back 0x00 then 0xFF with `valid` held high → second start bit begins at E0+41. Exactly one high cycle separates the first frame's stop bit from the second frame's start bit.
- While sending 0x3C:
  - pulse `valid` with `data`=0x99 at cycle E0+12 → ignored;
  - change `data` at E0+5 → ignored;
  - line shows 0x3C only, and no second frame follows.
- `reset` asserted during data bit 3 of 0xF0 → `TXD`=1 asynchronously. After release, sending 0x55 produces a complete, correct frame.
- Boundary N=2, byte 0x80 → frame lasts 20 cycles. `TXD` is low for 16 consecutive cycles (start + bits 0–6), then high for 4 (bit 7 + stop).
